// File: rtl/arb_requester.sv
// Requester-side agent for a 4-way req/gnt arbiter: queues per-master jobs,
// raises req, accepts one-hot grants in IDLE and runs a fixed-length burst.
module arb_requester #(
  parameter int unsigned N         = 4,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] new_req,
  input  logic [N-1:0] gnt,
  output logic [N-1:0] req,
  output logic [1:0]   active_id,
  output logic         beat_valid,
  output logic         beat_last,
  output logic         busy,
  output logic [N-1:0] overflow,
  output logic         gnt_err
);

  localparam int unsigned ID_W   = 2;
  localparam int unsigned BEAT_W = 4;
  localparam logic [CNT_W-1:0]  PEND_MAX  = '1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ID_W-1:0]   id_d;
  logic              last_d;
  logic              busy_d;
  logic              gnt_err_d;
  logic              accept;
  logic              gnt_onehot;
  logic [ID_W-1:0]   gnt_id;
  logic [CNT_W-1:0]  pend_q [N];
  logic [CNT_W-1:0]  pend_d [N];
  logic [N-1:0]      overflow_d;

  // Request bits come from registered state only.
  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = (pend_q[i] != '0) && !(busy && (active_id == ID_W'(i)));
    end
  end

  // Grant decode: one-hot check and index of the granted master.
  always_comb begin
    gnt_onehot = (gnt != '0) && ((gnt & (gnt - N'(1))) == '0);
    gnt_id     = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_id = ID_W'(i);
    end
    accept = (state_q == IDLE) && gnt_onehot && ((gnt & req) != '0);
  end

  // Burst sequencing.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    id_d      = active_id;
    last_d    = 1'b0;
    busy_d    = 1'b0;
    gnt_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BURST;
          beat_d  = '0;
          id_d    = gnt_id;
          busy_d  = 1'b1;
          last_d  = (BEAT_LAST == '0);
        end else if (gnt != '0) begin
          gnt_err_d = 1'b1;
        end
      end
      BURST: begin
        if (beat_last) begin
          state_d = IDLE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
          busy_d = 1'b1;
          last_d = ((beat_q + BEAT_W'(1)) == BEAT_LAST);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending-job counters; an accept and a new job in the same cycle cancel.
  always_comb begin
    overflow_d = overflow;
    for (int i = 0; i < N; i++) begin
      pend_d[i] = pend_q[i];
      if (new_req[i] && !(accept && gnt_id == ID_W'(i))) begin
        if (pend_q[i] == PEND_MAX) overflow_d[i] = 1'b1;
        else                       pend_d[i] = pend_q[i] + CNT_W'(1);
      end else if (!new_req[i] && accept && gnt_id == ID_W'(i)) begin
        pend_d[i] = pend_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      active_id  <= '0;
      beat_valid <= 1'b0;
      beat_last  <= 1'b0;
      busy       <= 1'b0;
      gnt_err    <= 1'b0;
      overflow   <= '0;
      for (int i = 0; i < N; i++) pend_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      active_id  <= id_d;
      beat_valid <= busy_d;
      beat_last  <= last_d;
      busy       <= busy_d;
      gnt_err    <= gnt_err_d;
      overflow   <= overflow_d;
      for (int i = 0; i < N; i++) pend_q[i] <= pend_d[i];
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: vector table plus saturation and
// mid-burst reset sequences.
module tb_arb_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] new_req;
  logic [3:0] gnt;
  logic [3:0] req;
  logic [1:0] active_id;
  logic       beat_valid;
  logic       beat_last;
  logic       busy;
  logic [3:0] overflow;
  logic       gnt_err;

  int checks = 0;
  int errors = 0;

  arb_requester #(.N(4), .BURST_LEN(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .new_req   (new_req),
    .gnt       (gnt),
    .req       (req),
    .active_id (active_id),
    .beat_valid(beat_valid),
    .beat_last (beat_last),
    .busy      (busy),
    .overflow  (overflow),
    .gnt_err   (gnt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] nr;
    logic [3:0] g;
    logic [3:0] e_req;
    logic       e_busy;
    logic       e_last;
    logic [1:0] e_id;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic [3:0] nr, input logic [3:0] g, input logic [3:0] er,
                     input logic eb, input logic el, input logic [1:0] ea, input logic ee);
    vec_t v;
    v.nr = nr; v.g = g; v.e_req = er; v.e_busy = eb; v.e_last = el; v.e_id = ea; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int bursts;
    int errs_seen;
    rst = 1'b0; new_req = '0; gnt = '0;
    #10;
    chk("rst_req", 32'(req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(beat_valid), 0);
    chk("rst_last", 32'(beat_last), 0);
    chk("rst_id", 32'(active_id), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_err", 32'(gnt_err), 0);
    rst = 1'b1;

    // single job
    row(4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 0);
    row(4'b0000, 4'b0001, 4'b0001, 0, 0, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    // competing masters 1 and 3
    row(4'b1010, 4'b0000, 4'b0000, 0, 0, 0, 0);
    row(4'b0000, 4'b0010, 4'b1010, 0, 0, 0, 0);
    row(4'b0000, 4'b0000, 4'b1000, 1, 0, 1, 0);
    row(4'b0000, 4'b0000, 4'b1000, 1, 0, 1, 0);
    row(4'b0000, 4'b0000, 4'b1000, 1, 0, 1, 0);
    row(4'b0000, 4'b0000, 4'b1000, 1, 1, 1, 0);
    row(4'b0000, 4'b1000, 4'b1000, 0, 0, 1, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 0, 3, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 0, 3, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 0, 3, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 1, 3, 0);
    row(4'b0000, 4'b0000, 4'b0000, 0, 0, 3, 0);
    // illegal grants in IDLE
    row(4'b0000, 4'b0011, 4'b0000, 0, 0, 3, 0);
    row(4'b0000, 4'b0000, 4'b0000, 0, 0, 3, 1);
    row(4'b0000, 4'b0100, 4'b0000, 0, 0, 3, 0);
    row(4'b0000, 4'b0000, 4'b0000, 0, 0, 3, 1);
    // grant held through a burst raises no error
    row(4'b0001, 4'b0000, 4'b0000, 0, 0, 3, 0);
    row(4'b0000, 4'b0001, 4'b0001, 0, 0, 3, 0);
    row(4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 0);
    row(4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 0);
    row(4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 0);
    row(4'b0000, 4'b0001, 4'b0000, 1, 1, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    // enqueue in the same cycle as the accept
    row(4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 0);
    row(4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0);
    row(4'b0000, 4'b0001, 4'b0001, 0, 0, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0);
    row(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);

    foreach (vecs[k]) begin
      @(negedge clk);
      chk($sformatf("v%0d_req", k), 32'(req), 32'(vecs[k].e_req));
      chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].e_busy));
      chk($sformatf("v%0d_valid", k), 32'(beat_valid), 32'(vecs[k].e_busy));
      chk($sformatf("v%0d_last", k), 32'(beat_last), 32'(vecs[k].e_last));
      chk($sformatf("v%0d_id", k), 32'(active_id), 32'(vecs[k].e_id));
      chk($sformatf("v%0d_err", k), 32'(gnt_err), 32'(vecs[k].e_err));
      new_req = vecs[k].nr;
      gnt     = vecs[k].g;
    end
    chk("tbl_ovf", 32'(overflow), 0);

    // saturation of master 2: 7 jobs kept, the 8th dropped
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 7) chk("sat_ovf_before", 32'(overflow), 0);
      if (k == 1) chk("sat_req", 32'(req), 32'(4'b0100));
      new_req = 4'b0100;
      gnt     = '0;
    end
    @(negedge clk);
    new_req = '0;
    chk("sat_ovf_after", 32'(overflow), 32'(4'b0100));
    bursts = 0; errs_seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (beat_last) bursts++;
      if (gnt_err) errs_seen++;
      gnt = (!busy && req[2]) ? 4'b0100 : 4'b0000;
    end
    chk("sat_bursts", 32'(bursts), 7);
    chk("sat_errs", 32'(errs_seen), 0);
    chk("sat_req_end", 32'(req), 0);
    chk("sat_ovf_sticky", 32'(overflow), 32'(4'b0100));

    // reset in the second beat aborts at once
    @(negedge clk); new_req = 4'b0010; gnt = '0;
    @(negedge clk); new_req = 4'b0010;
    @(negedge clk); new_req = '0; gnt = 4'b0010;
    @(negedge clk); gnt = '0;
    chk("mr_beat1", 32'(busy), 1);
    @(negedge clk);
    chk("mr_beat2", 32'(beat_valid), 1);
    chk("mr_req_pre", 32'(req), 32'(4'b0000));
    #2 rst = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_valid", 32'(beat_valid), 0);
    chk("mr_req", 32'(req), 0);
    chk("mr_ovf", 32'(overflow), 0);
    errs_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (beat_last) errs_seen++;
    end
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (beat_last || busy) errs_seen++;
    end
    chk("mr_no_last", 32'(errs_seen), 0);
    chk("mr_req_after", 32'(req), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
